// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, kernel/stride encodings and output-geometry helpers for the conv sequencer.
package conv_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, WLOAD, STREAM, DONE} state_t;
  typedef enum logic {KSIZE_1X1 = 1'b0, KSIZE_3X3 = 1'b1} ksize_t;
  typedef enum logic {STRIDE_1 = 1'b0, STRIDE_2 = 1'b1} stride_t;
  function automatic int calc_oh(int size, int k, logic stride);
    return ((size - k) >> stride) + 1;
  endfunction
  function automatic int calc_npass(int oh, int col);
    return (oh + col - 1) / col;
  endfunction
endpackage

// File: rtl/conv2d_kxk_seq_if.sv
// conv2d_kxk_seq_if: config/start, fetch handshake and PE-array control bundle of the conv sequencer.
interface conv2d_kxk_seq_if #(
  parameter int COL       = 8,
  parameter int CHN_WIDTH = 4,
  parameter int FMS_WIDTH = 8
);
  logic                 start;
  logic                 cfg_ksize;
  logic                 cfg_stride;
  logic [CHN_WIDTH-1:0] cfg_ci;
  logic [CHN_WIDTH-1:0] cfg_co;
  logic [FMS_WIDTH-1:0] cfg_ifm_size;
  logic                 wgt_valid;
  logic                 ifm_valid;
  logic                 stall;
  logic                 busy;
  logic                 wgt_read;
  logic                 ifm_read;
  logic [COL-1:0]       pvalid;
  logic                 ic_done;
  logic                 oc_done;
  logic                 conv_done;
  modport master (
    output start, cfg_ksize, cfg_stride, cfg_ci, cfg_co, cfg_ifm_size, wgt_valid, ifm_valid, stall,
    input  busy, wgt_read, ifm_read, pvalid, ic_done, oc_done, conv_done
  );
  modport slave (
    input  start, cfg_ksize, cfg_stride, cfg_ci, cfg_co, cfg_ifm_size, wgt_valid, ifm_valid, stall,
    output busy, wgt_read, ifm_read, pvalid, ic_done, oc_done, conv_done
  );
endinterface

// File: rtl/conv_loop_cnt.sv
// conv_loop_cnt: loop counter that holds at its limit and wraps to 0 when advanced past it.
module conv_loop_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);
  logic [W-1:0] r_cnt;
  assign o_cnt  = r_cnt;
  assign o_last = r_cnt == i_limit;
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en)    r_cnt <= o_last ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/conv2d_kxk_seq.sv
// conv2d_kxk_seq: oc/pass/ic loop sequencer driving weight/ifm fetch strobes and per-column accumulate enables.
module conv2d_kxk_seq
  import conv_pkg::*;
#(
  parameter int COL        = 8,
  parameter int CHN_WIDTH  = 4,
  parameter int FMS_WIDTH  = 8,
  parameter int PASS_WIDTH = 6
) (
  input logic              clk,
  input logic              rst,
  conv2d_kxk_seq_if.slave  bus
);
  state_t                r_state;
  ksize_t                r_ksize;
  logic                  r_stride, r_busy, r_conv_done;
  logic [CHN_WIDTH-1:0]  r_ci, r_co;
  logic [FMS_WIDTH-1:0]  r_size, r_oh;
  logic [1:0]            r_k;
  logic [PASS_WIDTH-1:0] r_npass_m1;
  logic [1:0]            w_k, w_km1;
  int                    w_oh;
  logic [FMS_WIDTH-1:0]  w_c, w_c_lim;
  logic [PASS_WIDTH-1:0] w_pass;
  logic [CHN_WIDTH-1:0]  w_ic_unused, w_oc_unused;
  logic                  w_c_last, w_ic_last, w_pass_last, w_oc_last;
  logic                  w_wbeat, w_ibeat, w_iter_end, w_ic_end, w_pass_end, w_all_end, w_pv_ok;
  logic [COL-1:0]        w_pvalid;
  assign w_k        = (r_ksize == KSIZE_3X3) ? 2'd3 : 2'd1;
  assign w_km1      = r_k - 2'd1;
  assign w_oh       = calc_oh(int'(r_size), int'(w_k), r_stride);
  assign w_wbeat    = (r_state == WLOAD) && !bus.stall && bus.wgt_valid;
  assign w_ibeat    = (r_state == STREAM) && !bus.stall && bus.ifm_valid;
  assign w_iter_end = w_ibeat && w_c_last;
  assign w_ic_end   = w_iter_end && w_ic_last;
  assign w_pass_end = w_ic_end && w_pass_last;
  assign w_all_end  = w_pass_end && w_oc_last;
  // The column counter also paces the K weight beats of WLOAD.
  assign w_c_lim    = (r_state == WLOAD) ? FMS_WIDTH'(w_km1) : r_size - 1'b1;
  conv_loop_cnt #(.W(FMS_WIDTH)) u_c (
    .clk(clk), .rst(rst), .i_clr(r_state == SETUP), .i_en(w_wbeat || w_ibeat),
    .i_limit(w_c_lim), .o_cnt(w_c), .o_last(w_c_last));
  conv_loop_cnt #(.W(CHN_WIDTH)) u_ic (
    .clk(clk), .rst(rst), .i_clr(r_state == SETUP), .i_en(w_iter_end),
    .i_limit(r_ci), .o_cnt(w_ic_unused), .o_last(w_ic_last));
  conv_loop_cnt #(.W(PASS_WIDTH)) u_pass (
    .clk(clk), .rst(rst), .i_clr(r_state == SETUP), .i_en(w_ic_end),
    .i_limit(r_npass_m1), .o_cnt(w_pass), .o_last(w_pass_last));
  conv_loop_cnt #(.W(CHN_WIDTH)) u_oc (
    .clk(clk), .rst(rst), .i_clr(r_state == SETUP), .i_en(w_pass_end),
    .i_limit(r_co), .o_cnt(w_oc_unused), .o_last(w_oc_last));
  // Stride 2 keeps every other valid window; the LSB of c-(K-1) is c[0]^(K-1)[0].
  always_comb begin
    w_pv_ok  = w_ibeat && (w_c >= FMS_WIDTH'(w_km1)) && !(r_stride && (w_c[0] ^ w_km1[0]));
    w_pvalid = '0;
    for (int i = 0; i < COL; i++)
      w_pvalid[i] = w_pv_ok && (int'(w_pass) * COL + i < int'(r_oh));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_conv_done <= 1'b0;
      r_ksize     <= KSIZE_1X1;
      r_stride    <= 1'b0;
      r_ci        <= '0;
      r_co        <= '0;
      r_size      <= '0;
      r_k         <= '0;
      r_oh        <= '0;
      r_npass_m1  <= '0;
    end else begin
      r_conv_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_ksize  <= ksize_t'(bus.cfg_ksize);
          r_stride <= bus.cfg_stride;
          r_ci     <= bus.cfg_ci;
          r_co     <= bus.cfg_co;
          r_size   <= bus.cfg_ifm_size;
          r_busy   <= 1'b1;
          r_state  <= SETUP;
        end
        SETUP: begin
          r_k        <= w_k;
          r_oh       <= FMS_WIDTH'(w_oh);
          r_npass_m1 <= PASS_WIDTH'(calc_npass(w_oh, COL) - 1);
          if (r_size < FMS_WIDTH'(w_k)) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_conv_done <= 1'b1;
          end else r_state <= WLOAD;
        end
        WLOAD: if (w_wbeat && w_c_last) r_state <= STREAM;
        STREAM: if (w_iter_end) begin
          r_state     <= w_all_end ? DONE : WLOAD;
          r_busy      <= !w_all_end;
          r_conv_done <= w_all_end;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy      = r_busy;
  assign bus.conv_done = r_conv_done;
  assign bus.wgt_read  = (r_state == WLOAD) && !bus.stall;
  assign bus.ifm_read  = (r_state == STREAM) && !bus.stall;
  assign bus.pvalid    = w_pvalid;
  assign bus.ic_done   = w_ic_end;
  assign bus.oc_done   = w_pass_end;
endmodule
